lsu_ctrl: RTL and testbench

Load/store unit sitting between the core's execute stage and the data memory. It accepts one byte, halfword or word access per request, splits unaligned accesses that cross a word boundary into two aligned word accesses, and performs read-modify-write for sub-word stores, because the memory port has only a whole-word write enable. It returns sign- or zero-extended load data with a one-cycle `done` pulse.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_ctrl_if.sv | 27 ++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings,
// default memory window, and funct3 decode helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h8000_0000;
  localparam int unsigned DEF_SIZE_BYTES = 1024;

  function automatic logic f3_legal(input logic [2:0] f3, input logic st);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !st;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_nbytes = 3'd1;
      F3_H, F3_HU: f3_nbytes = 3'd2;
      default:     f3_nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    f3_signed = (f3 == F3_B) || (f3 == F3_H);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and memory-port signals of the load/store unit.
// slave = the LSU itself; master = core plus data memory driving it.
interface lsu_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req, we, funct3, addr, wdata, mem_rd,
    input  busy, done, err, rdata, mem_a, mem_we, mem_wd
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rd,
    output busy, done, err, rdata, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: load extract/extend from the {hi,lo} word pair
// and byte-masked store merge into the same pair; zero latency, no handshake.
module lsu_align (
  input  logic [1:0]  off,
  input  logic [2:0]  nbytes,
  input  logic        sign,
  input  logic [31:0] lo_buf,
  input  logic [31:0] hi_buf,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_lo,
  output logic [31:0] st_hi
);

  logic [63:0] pair;
  logic [63:0] st_shift;
  logic [63:0] mask;
  logic [63:0] merged;
  logic [31:0] raw;
  logic [7:0]  bmask;

  always_comb begin
    pair    = {hi_buf, lo_buf};
    raw     = 32'(pair >> {off, 3'b000});
    ld_data = raw;
    case (nbytes)
      3'd1:    ld_data = sign ? {{24{raw[7]}}, raw[7:0]}   : {24'b0, raw[7:0]};
      3'd2:    ld_data = sign ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
      default: ld_data = raw;
    endcase

    // Byte enables across both words; bytes outside them keep the read-back value.
    bmask = ((nbytes == 3'd1) ? 8'h01 : (nbytes == 3'd2) ? 8'h03 : 8'h0F) << off;
    mask  = '0;
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{bmask[i]}};
    end
    st_shift = {32'b0, wdata} << {off, 3'b000};
    merged   = (pair & ~mask) | (st_shift & mask);
    st_lo    = merged[31:0];
    st_hi    = merged[63:32];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: splits word-crossing accesses and does read-modify-write for sub-word stores.
// Done 1..5 cycles after accept; requests seen while busy are ignored, not queued.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int unsigned SIZE_BYTES = DEF_SIZE_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);

  state_t      state;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_buf;
  logic [31:0] hi_buf;
  logic [31:0] rdata_q;
  logic        err_q;

  function automatic logic in_win(input logic [31:0] a);
    logic [31:0] rel;
    rel    = a - BASE_ADDR;
    in_win = rel <= (SIZE_BYTES - 32'd4);
  endfunction

  // Fault check on the incoming request, before anything is latched.
  logic [31:0] in_lo_a;
  logic [31:0] in_hi_a;
  logic        in_span;
  logic        acc_fault;
  logic        acc_sw_aligned;

  assign in_lo_a   = {bus.addr[31:2], 2'b00};
  assign in_hi_a   = in_lo_a + 32'd4;
  assign in_span   = ({1'b0, bus.addr[1:0]} + f3_nbytes(bus.funct3)) > 3'd4;
  assign acc_fault = !f3_legal(bus.funct3, bus.we) || !in_win(in_lo_a) ||
                     (in_span && !in_win(in_hi_a));
  assign acc_sw_aligned = bus.we && (bus.funct3 == F3_W) && (bus.addr[1:0] == 2'b00);

  logic [31:0] lo_a_q;
  logic [31:0] hi_a_q;
  logic [2:0]  nbytes_q;
  logic        span_q;

  assign lo_a_q   = {addr_q[31:2], 2'b00};
  assign hi_a_q   = lo_a_q + 32'd4;
  assign nbytes_q = f3_nbytes(f3_q);
  assign span_q   = ({1'b0, addr_q[1:0]} + nbytes_q) > 3'd4;

  // The word being read this cycle feeds the extractor directly so rdata can load on DONE entry.
  logic [31:0] lo_eff;
  logic [31:0] hi_eff;
  logic [31:0] ld_data;
  logic [31:0] st_lo;
  logic [31:0] st_hi;

  assign lo_eff = (state == RD_LO) ? bus.mem_rd : lo_buf;
  assign hi_eff = (state == RD_HI) ? bus.mem_rd : hi_buf;

  lsu_align u_align (
    .off     (addr_q[1:0]),
    .nbytes  (nbytes_q),
    .sign    (f3_signed(f3_q)),
    .lo_buf  (lo_eff),
    .hi_buf  (hi_eff),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_lo   (st_lo),
    .st_hi   (st_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wdata_q <= '0;
      lo_buf  <= '0;
      hi_buf  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.we;
            f3_q    <= bus.funct3;
            wdata_q <= bus.wdata;
            err_q   <= acc_fault;
            if (acc_fault)           state <= DONE;
            else if (acc_sw_aligned) state <= WR_LO;
            else                     state <= RD_LO;
          end else begin
            err_q <= 1'b0;
            state <= IDLE;
          end
        end
        RD_LO: begin
          lo_buf <= bus.mem_rd;
          if (span_q)    state <= RD_HI;
          else if (we_q) state <= WR_LO;
          else begin
            rdata_q <= ld_data;
            state   <= DONE;
          end
        end
        RD_HI: begin
          hi_buf <= bus.mem_rd;
          if (we_q) state <= WR_LO;
          else begin
            rdata_q <= ld_data;
            state   <= DONE;
          end
        end
        WR_LO:   state <= span_q ? WR_HI : DONE;
        WR_HI:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_a  = '0;
    bus.mem_we = 1'b0;
    bus.mem_wd = '0;
    case (state)
      RD_LO: bus.mem_a = lo_a_q;
      RD_HI: bus.mem_a = hi_a_q;
      WR_LO: begin
        bus.mem_a  = lo_a_q;
        bus.mem_we = 1'b1;
        bus.mem_wd = st_lo;
      end
      WR_HI: begin
        bus.mem_a  = hi_a_q;
        bus.mem_we = 1'b1;
        bus.mem_wd = st_hi;
      end
      default: ;
    endcase
  end

  assign bus.busy  = (state != IDLE) && (state != DONE);
  assign bus.done  = (state == DONE);
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl against a 256-word memory model with a write log.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if ifc ();

  lsu_ctrl #(.BASE_ADDR(BASE), .SIZE_BYTES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  logic [31:0] mem [0:255];
  logic [31:0] wr_a [$];
  logic [31:0] wr_d [$];
  int          wr_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  assign ifc.mem_rd = mem[ifc.mem_a[9:2]];

  always @(posedge clk) begin
    if (ifc.mem_we) begin
      mem[ifc.mem_a[9:2]] = ifc.mem_wd;
      wr_a.push_back(ifc.mem_a);
      wr_d.push_back(ifc.mem_wd);
      wr_cnt++;
    end
  end

  // Called at a negedge; returns at the negedge where done is seen (lat = edges after accept).
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    ifc.req = 1'b1; ifc.we = w; ifc.funct3 = f3; ifc.addr = a; ifc.wdata = d;
    @(posedge clk);
    #1 ifc.req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ifc.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({ifc.busy, ifc.done, ifc.err, ifc.mem_we} !== 4'b0000) begin failures++;
      $display("FAIL reset_flags got=%b exp=0000", {ifc.busy, ifc.done, ifc.err, ifc.mem_we}); end
    checks++; if (ifc.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", ifc.rdata); end
    checks++; if (ifc.mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", ifc.mem_a); end
    checks++; if (ifc.mem_wd !== 32'h0) begin failures++; $display("FAIL reset_mem_wd got=%h exp=0", ifc.mem_wd); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned_lw();
    int lat; int n0;
    mem[4] = 32'h1122_3344;
    n0 = wr_cnt;
    do_op(1'b0, F3_W, 32'h8000_0010, 32'h0, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL lw_lat got=%0d exp=2", lat); end
    checks++; if (ifc.rdata !== 32'h1122_3344) begin failures++; $display("FAIL lw_rdata got=%h exp=11223344", ifc.rdata); end
    checks++; if (ifc.err !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", ifc.err); end
    checks++; if (wr_cnt != n0) begin failures++; $display("FAIL lw_nowrite got=%0d exp=%0d", wr_cnt, n0); end
  endtask

  task automatic test_subword_load();
    int lat;
    mem[4] = 32'h80FF_0000;
    do_op(1'b0, F3_B, 32'h8000_0013, 32'h0, lat);
    checks++; if (lat != 2 || ifc.rdata !== 32'hFFFF_FF80) begin failures++;
      $display("FAIL lb got=%h lat=%0d exp=ffffff80 lat=2", ifc.rdata, lat); end
    do_op(1'b0, F3_BU, 32'h8000_0013, 32'h0, lat);
    checks++; if (ifc.rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu got=%h exp=00000080", ifc.rdata); end
    do_op(1'b0, F3_H, 32'h8000_0012, 32'h0, lat);
    checks++; if (ifc.rdata !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh got=%h exp=ffff80ff", ifc.rdata); end
    do_op(1'b0, F3_HU, 32'h8000_0012, 32'h0, lat);
    checks++; if (ifc.rdata !== 32'h0000_80FF) begin failures++; $display("FAIL lhu got=%h exp=000080ff", ifc.rdata); end
  endtask

  task automatic test_sh_rmw();
    int lat; int n0;
    mem[8] = 32'hAABB_CCDD;
    n0 = wr_cnt;
    do_op(1'b1, F3_H, 32'h8000_0021, 32'h0000_BEEF, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL sh_lat got=%0d exp=3", lat); end
    checks++; if (wr_cnt != n0 + 1) begin failures++; $display("FAIL sh_wcount got=%0d exp=%0d", wr_cnt, n0 + 1); end
    else begin
      checks++; if (wr_a[n0] !== 32'h8000_0020 || wr_d[n0] !== 32'hAABE_EFDD) begin failures++;
        $display("FAIL sh_write got=%h:%h exp=80000020:aabeefdd", wr_a[n0], wr_d[n0]); end
    end
  endtask

  task automatic test_span_store_load();
    int lat; int n0;
    mem[16] = 32'h0; mem[17] = 32'h0;
    n0 = wr_cnt;
    do_op(1'b1, F3_W, 32'h8000_0043, 32'h0403_0201, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL spsw_lat got=%0d exp=5", lat); end
    checks++; if (wr_cnt != n0 + 2) begin failures++; $display("FAIL spsw_wcount got=%0d exp=%0d", wr_cnt, n0 + 2); end
    else begin
      checks++; if (wr_a[n0] !== 32'h8000_0040 || wr_d[n0] !== 32'h0100_0000) begin failures++;
        $display("FAIL spsw_lo got=%h:%h exp=80000040:01000000", wr_a[n0], wr_d[n0]); end
      checks++; if (wr_a[n0+1] !== 32'h8000_0044 || wr_d[n0+1] !== 32'h0004_0302) begin failures++;
        $display("FAIL spsw_hi got=%h:%h exp=80000044:00040302", wr_a[n0+1], wr_d[n0+1]); end
    end
    do_op(1'b0, F3_W, 32'h8000_0042, 32'h0, lat);
    checks++; if (lat != 3 || ifc.rdata !== 32'h0302_0100) begin failures++;
      $display("FAIL splw got=%h lat=%0d exp=03020100 lat=3", ifc.rdata, lat); end
  endtask

  task automatic test_aligned_sw_and_edge();
    int lat; int n0;
    n0 = wr_cnt;
    do_op(1'b1, F3_W, 32'h8000_0050, 32'hDEAD_BEEF, lat);
    checks++; if (lat != 2 || wr_cnt != n0 + 1 || mem[20] !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL sw got lat=%0d writes=%0d mem=%h exp lat=2 writes=%0d mem=deadbeef", lat, wr_cnt - n0, mem[20], 1); end
    do_op(1'b1, F3_W, 32'h8000_03FC, 32'h5555_AAAA, lat);
    checks++; if (ifc.err !== 1'b0 || mem[255] !== 32'h5555_AAAA) begin failures++;
      $display("FAIL last_word got err=%b mem=%h exp err=0 mem=5555aaaa", ifc.err, mem[255]); end
  endtask

  task automatic test_faults();
    int lat; int n0;
    n0 = wr_cnt;
    do_op(1'b0, F3_W, 32'h8000_03FE, 32'h0, lat);
    checks++; if (lat != 1 || ifc.err !== 1'b1) begin failures++; $display("FAIL flt_span got lat=%0d err=%b exp lat=1 err=1", lat, ifc.err); end
    checks++; if (ifc.rdata !== 32'h0302_0100) begin failures++; $display("FAIL flt_rdata_hold got=%h exp=03020100", ifc.rdata); end
    do_op(1'b1, F3_B, 32'h7FFF_FFFC, 32'hFF, lat);
    checks++; if (lat != 1 || ifc.err !== 1'b1) begin failures++; $display("FAIL flt_below got lat=%0d err=%b exp lat=1 err=1", lat, ifc.err); end
    do_op(1'b0, F3_B, 32'h8000_0400, 32'h0, lat);
    checks++; if (lat != 1 || ifc.err !== 1'b1) begin failures++; $display("FAIL flt_above got lat=%0d err=%b exp lat=1 err=1", lat, ifc.err); end
    do_op(1'b1, F3_BU, 32'h8000_0010, 32'h1, lat);
    checks++; if (lat != 1 || ifc.err !== 1'b1) begin failures++; $display("FAIL flt_sbu got lat=%0d err=%b exp lat=1 err=1", lat, ifc.err); end
    do_op(1'b0, 3'b011, 32'h8000_0010, 32'h0, lat);
    checks++; if (lat != 1 || ifc.err !== 1'b1) begin failures++; $display("FAIL flt_f3 got lat=%0d err=%b exp lat=1 err=1", lat, ifc.err); end
    checks++; if (wr_cnt != n0) begin failures++; $display("FAIL flt_nowrite got=%0d exp=%0d", wr_cnt, n0); end
    @(negedge clk);
    checks++; if ({ifc.busy, ifc.done, ifc.err} !== 3'b000) begin failures++;
      $display("FAIL idle_after_done got=%b exp=000", {ifc.busy, ifc.done, ifc.err}); end
  endtask

  task automatic test_busy_ignore();
    int lat; int n0;
    mem[24] = 32'h1111_1111; mem[25] = 32'h2222_2222;
    n0 = wr_cnt;
    ifc.req = 1'b1; ifc.we = 1'b0; ifc.funct3 = F3_W; ifc.addr = 32'h8000_0062;
    @(posedge clk);
    #1 ifc.req = 1'b0;
    @(negedge clk);
    checks++; if (ifc.busy !== 1'b1) begin failures++; $display("FAIL busy got=%b exp=1", ifc.busy); end
    ifc.req = 1'b1; ifc.we = 1'b1; ifc.funct3 = F3_W; ifc.addr = 32'h8000_0070; ifc.wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 ifc.req = 1'b0;
    lat = 0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (ifc.done) begin lat = k; break; end
    end
    checks++; if (lat != 3 || ifc.rdata !== 32'h2222_1111) begin failures++;
      $display("FAIL busy_load got=%h lat=%0d exp=22221111 lat=3", ifc.rdata, lat); end
    checks++; if (wr_cnt != n0) begin failures++; $display("FAIL busy_ignored got=%0d exp=%0d", wr_cnt, n0); end
  endtask

  task automatic test_reset_mid();
    int lat; int n0;
    mem[32] = 32'hCAFE_F00D; mem[33] = 32'h1234_5678;
    n0 = wr_cnt;
    ifc.req = 1'b1; ifc.we = 1'b1; ifc.funct3 = F3_W; ifc.addr = 32'h8000_0081; ifc.wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 ifc.req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ifc.busy !== 1'b1 || ifc.mem_a !== 32'h8000_0084) begin failures++;
      $display("FAIL rd_hi got busy=%b a=%h exp busy=1 a=80000084", ifc.busy, ifc.mem_a); end
    rst = 1'b1;
    #1;
    checks++; if ({ifc.busy, ifc.done, ifc.err, ifc.mem_we} !== 4'b0000 || ifc.mem_a !== 32'h0 ||
                  ifc.mem_wd !== 32'h0 || ifc.rdata !== 32'h0) begin failures++;
      $display("FAIL mid_reset got flags=%b a=%h wd=%h rd=%h exp 0", {ifc.busy, ifc.done, ifc.err, ifc.mem_we},
               ifc.mem_a, ifc.mem_wd, ifc.rdata); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt != n0 || mem[32] !== 32'hCAFE_F00D || mem[33] !== 32'h1234_5678) begin failures++;
      $display("FAIL mid_reset_mem got writes=%0d %h %h exp 0 cafef00d 12345678", wr_cnt - n0, mem[32], mem[33]); end
    do_op(1'b0, F3_W, 32'h8000_0080, 32'h0, lat);
    checks++; if (lat != 2 || ifc.rdata !== 32'hCAFE_F00D) begin failures++;
      $display("FAIL post_reset_lw got=%h lat=%0d exp=cafef00d lat=2", ifc.rdata, lat); end
  endtask

  initial begin
    ifc.req = 1'b0; ifc.we = 1'b0; ifc.funct3 = 3'b0; ifc.addr = 32'h0; ifc.wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_aligned_lw();
    test_subword_load();
    test_sh_rmw();
    test_span_store_load();
    test_aligned_sw_and_edge();
    test_faults();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
